arbiter_mux2x1: RTL
===================

ARBITER_MUX2X1 -- requirements
Module: arbiter_mux2x1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, lane and output data width.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, maximum consecutive words per grant (legal range 1-15).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port In0, input, DATA_W, lane 0 data.
REQ-006 The block SHALL have port valid0, input, 1, lane 0 has a word available.
REQ-007 The block SHALL have port pop0, output, 1, lane 0 word consumed this cycle.
REQ-008 The block SHALL have ports In1/valid1/pop1 with the same widths and meanings for lane 1.
REQ-009 The block SHALL have port out_ready, input, 1, downstream can accept a word this cycle.
REQ-010 The block SHALL have port data_out, output, DATA_W, registered selected word.
REQ-011 The block SHALL have port outValid, output, 1, data_out holds a new word this cycle.
REQ-012 The block SHALL have port grant, output, 2, one-hot current grant (01 lane 0, 10 lane 1, 00 idle).

Function
REQ-013 The FSM SHALL have states IDLE, GRANT0 and GRANT1, with registered state and grant = one-hot of state.
REQ-014 In IDLE, it SHALL move to GRANT of the single valid lane; if both are valid, it SHALL go to the lane opposite last_grant.
REQ-015 In GRANTi, popi SHALL be combinational: popi = valid_i & out_ready; the other pop SHALL be 0; in IDLE both pops SHALL be 0.
REQ-016 On a pop, data_out SHALL load the granted In at the next edge and outValid SHALL be 1 for that cycle, giving a latency of exactly 1 cycle.
REQ-017 In cycles without a pop, outValid SHALL be 0 and data_out SHALL hold its last value.
REQ-018 burst_cnt (4 bits) SHALL increment on each pop and clear on every state change.
REQ-019 In GRANTi, if a pop occurs with burst_cnt == BURST_MAX-1 and the other lane is valid, the FSM SHALL move to GRANT_other.
REQ-020 In GRANTi with valid_i low, the FSM SHALL move to GRANT_other if the other lane is valid, else to IDLE.
REQ-021 Otherwise the FSM SHALL stay in GRANTi; when burst_cnt reaches BURST_MAX-1 and the other lane is idle, it SHALL saturate there (no wrap) and the grant continues.
REQ-022 out_ready low SHALL freeze state and burst_cnt, with no pop and outValid 0.
REQ-023 last_grant SHALL update to i on every entry into GRANTi.

Reset
REQ-024 While reset_L = 0, the block SHALL asynchronously force state = IDLE, burst_cnt = 0, last_grant = 1, data_out = 0, outValid = 0, grant = 00, pop0 = pop1 = 0.
REQ-025 Reset mid-burst SHALL discard the burst, lose no popped word already registered, and restart arbitration with lane 0 first.

Configuration
REQ-026 With macro ARB_STRICT_PRIO_EN defined, lane 0 SHALL always win on a tie, BURST_MAX SHALL be ignored, and GRANT1 SHALL yield to GRANT0 after any lane 1 pop when valid0 = 1.
REQ-027 Without ARB_STRICT_PRIO_EN, round-robin with a burst limit (REQ-014, REQ-019) SHALL apply.

Structure
REQ-028 Package arb_pkg SHALL hold the state encoding localparams (IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10) and the DATA_W and BURST_MAX defaults.
REQ-029 The burst counter SHALL be a sub-module burst_counter (clear, enable, BURST_MAX-1 compare output).

Verification
REQ-030 Reset, then valid0 = 1 only with In0 = 0xA1..0xA6 and out_ready = 1: pop0 SHALL be asserted 6 consecutive cycles and data_out SHALL show 0xA1..0xA6 one cycle later, with grant staying 01.
REQ-031 Both lanes continuously valid, BURST_MAX = 4: the output SHALL be 4 lane-0 words, then 4 lane-1 words, alternating, with no idle cycle at switches.
REQ-032 out_ready driven low for 3 cycles mid-burst: pops and outValid SHALL be 0, data_out SHALL hold, and after release the burst SHALL resume with the count preserved.
REQ-033 valid0 drops after 2 words while valid1 = 1: the grant SHALL move to lane 1 next cycle; when both drop, the FSM SHALL go to IDLE with grant = 00.
REQ-034 Reset_L asserted during GRANT1: all outputs SHALL be 0 immediately; after release with both lanes valid, lane 0 SHALL be granted first.
REQ-035 With ARB_STRICT_PRIO_EN defined and both lanes valid: only lane 0 words SHALL appear until valid0 = 0.

Source files
------------

// File: rtl/arbiter_mux2x1_pkg.sv
// Shared definitions for the two-lane arbitrating mux: state encoding and parameter defaults.
package arb_pkg;

    typedef logic [1:0] state_t;

    // Encodings double as the one-hot grant vector.
    localparam state_t IDLE   = 2'b00;
    localparam state_t GRANT0 = 2'b01;
    localparam state_t GRANT1 = 2'b10;

    localparam int DATA_W_DEF    = 8;
    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W         = 4;

    function automatic state_t grant_of(input logic lane);
        return lane ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/arbiter_mux2x1_burst_counter.sv
// Per-grant word counter: clears on grant change, counts pops, and saturates at BURST_MAX-1.
module burst_counter
    import arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic enable,
    output logic at_max
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_MAX - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_max = (cnt_q == LAST);

endmodule

// File: rtl/arbiter_mux2x1.sv
// Two-lane round-robin arbiter with burst limit feeding a registered output word.
// Define ARB_STRICT_PRIO_EN for strict lane-0 priority (burst limit ignored).
module arbiter_mux2x1
    import arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] In0,
    input  logic              valid0,
    output logic              pop0,
    input  logic [DATA_W-1:0] In1,
    input  logic              valid1,
    output logic              pop1,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              outValid,
    output logic [1:0]        grant
);

    state_t            state_d, state_q;
    logic              last_grant_d, last_grant_q;
    logic [DATA_W-1:0] data_out_d, data_out_q;
    logic              out_valid_d, out_valid_q;
    logic              pop_any;
    logic              at_max;
    logic              state_chg;
    logic [1:0][DATA_W-1:0] lane_data;

    assign lane_data = {In1, In0};

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic; a stalled downstream freezes the arbiter entirely.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (out_ready) begin
            case (state_q)
                IDLE: begin
                    if (valid0 && valid1) begin
`ifdef ARB_STRICT_PRIO_EN
                        state_d = GRANT0;
`else
                        state_d = grant_of(~last_grant_q);
`endif
                    end else if (valid0) begin
                        state_d = GRANT0;
                    end else if (valid1) begin
                        state_d = GRANT1;
                    end
                end
                GRANT0: begin
                    if (!valid0)
                        state_d = valid1 ? GRANT1 : IDLE;
`ifndef ARB_STRICT_PRIO_EN
                    else if (at_max && valid1)
                        state_d = GRANT1;
`endif
                end
                GRANT1: begin
                    if (!valid1)
                        state_d = valid0 ? GRANT0 : IDLE;
`ifdef ARB_STRICT_PRIO_EN
                    else if (valid0)
                        state_d = GRANT0;
`else
                    else if (at_max && valid0)
                        state_d = GRANT0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        if ((state_d == GRANT0) && (state_q != GRANT0))
            last_grant_d = 1'b0;
        else if ((state_d == GRANT1) && (state_q != GRANT1))
            last_grant_d = 1'b1;
    end

    // Output logic: pops are combinational from the registered grant.
    always_comb begin
        grant       = state_q;
        pop0        = (state_q == GRANT0) && valid0 && out_ready;
        pop1        = (state_q == GRANT1) && valid1 && out_ready;
        pop_any     = pop0 | pop1;
        data_out_d  = pop_any ? lane_data[pop1] : data_out_q;
        out_valid_d = pop_any;
        state_chg   = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign outValid = out_valid_q;

    burst_counter #(
        .BURST_MAX (BURST_MAX)
    ) u_burst_counter (
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (state_chg),
        .enable  (pop_any),
        .at_max  (at_max)
    );

`ifdef ARB_STRICT_PRIO_EN
    logic unused_at_max;
    assign unused_at_max = at_max;
`endif

endmodule
